// File: rtl/reg_file_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package reg_file_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_PEND_W     = 2;
    localparam int ZERO_REG       = 0;
endpackage

// File: rtl/reg_pend_cnt.sv
// Per-register pending-write counter; the issue side is expected to stop
// incrementing once 'full' is seen, so the counter never wraps.
module reg_pend_cnt #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              nonzero,
    output logic              full
);
    logic [PEND_W-1:0] cnt_q, cnt_d;

    // Simultaneous claim and retire cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec)
            cnt_d = cnt_q + PEND_W'(1);
        else if (dec && !inc)
            cnt_d = cnt_q - PEND_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count   = cnt_q;
    assign nonzero = |cnt_q;
    assign full    = &cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write scoreboard.
// Define REG_FILE_WRITE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int PEND_W     = DEF_PEND_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  busy1,
    output logic                  busy2,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    output logic                  iss_ready,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wb_err
);
    localparam int REG_NUM = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]          mem_q [REG_NUM];
    logic [REG_NUM-1:0][PEND_W-1:0] pend;
    logic [REG_NUM-1:0]             nonzero;
    logic [REG_NUM-1:0]             full;
    logic                           wb_err_q, wb_err_d;
    logic                           iss_zero, fire, wr_nz, retire;

    assign pend[ZERO_REG]    = '0;
    assign nonzero[ZERO_REG] = 1'b0;
    assign full[ZERO_REG]    = 1'b0;

    assign iss_zero  = (iss_addr == ADDR_WIDTH'(ZERO_REG));
    assign iss_ready = iss_zero || !full[iss_addr];
    assign fire      = iss_valid && iss_ready && !iss_zero;
    assign wr_nz     = wen && (waddr != ADDR_WIDTH'(ZERO_REG));
    assign retire    = wr_nz && nonzero[waddr];

    for (genvar r = 1; r < REG_NUM; r++) begin : g_pend
        reg_pend_cnt #(.PEND_W(PEND_W)) u_cnt (
            .clk     (clk),
            .resetn  (resetn),
            .inc     (fire && (iss_addr == ADDR_WIDTH'(r))),
            .dec     (retire && (waddr == ADDR_WIDTH'(r))),
            .count   (pend[r]),
            .nonzero (nonzero[r]),
            .full    (full[r])
        );
    end

    // Register 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < REG_NUM; i++)
                mem_q[i] <= '0;
        end else if (wr_nz) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign wb_err_d = wb_err_q || (wr_nz && !nonzero[waddr]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wb_err_q <= 1'b0;
        else
            wb_err_q <= wb_err_d;
    end

    assign wb_err = wb_err_q;

`ifdef REG_FILE_WRITE_BYPASS_EN
    // A retiring last write clears busy in the same cycle it lands.
    always_comb begin
        rdata1 = mem_q[raddr1];
        rdata2 = mem_q[raddr2];
        busy1  = (pend[raddr1] != '0);
        busy2  = (pend[raddr2] != '0);
        if (wr_nz && (waddr == raddr1)) begin
            rdata1 = wdata;
            if (retire && (pend[raddr1] == PEND_W'(1)))
                busy1 = 1'b0;
        end
        if (wr_nz && (waddr == raddr2)) begin
            rdata2 = wdata;
            if (retire && (pend[raddr2] == PEND_W'(1)))
                busy2 = 1'b0;
        end
    end
`else
    always_comb begin
        rdata1 = mem_q[raddr1];
        rdata2 = mem_q[raddr2];
        busy1  = (pend[raddr1] != '0);
        busy2  = (pend[raddr2] != '0);
    end
`endif
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised general-purpose register file for the pipelined CPU. It adds a per-register pending-write scoreboard, so the decode stage can detect RAW hazards and the issue stage can be throttled. Two combinational read ports, one writeback port, one issue (destination-claim) port. Sits between decode/issue and writeback.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; REG_NUM = 2**ADDR_WIDTH
PEND_W, 2, width of per-register pending-write counter; max outstanding writes per register = 2**PEND_W-1

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  asynchronous, active-low reset
raddr1  in  ADDR_WIDTH  read port 1 index
raddr2  in  ADDR_WIDTH  read port 2 index
rdata1  out  DATA_WIDTH  read port 1 data (combinational)
rdata2  out  DATA_WIDTH  read port 2 data (combinational)
busy1  out  1  register raddr1 has outstanding writes
busy2  out  1  register raddr2 has outstanding writes
iss_valid  in  1  issuing instruction claims destination iss_addr
iss_addr  in  ADDR_WIDTH  destination index being claimed
iss_ready  out  1  claim can be accepted this cycle
wen  in  1  writeback enable
waddr  in  ADDR_WIDTH  writeback index
wdata  in  DATA_WIDTH  writeback data
wb_err  out  1  sticky flag: writeback to a register with zero pending count

Behaviour:
- Reset (resetn=0, async): all registers cleared to 0, all pending counters cleared to 0, wb_err cleared to 0. Effect is immediate, also mid-operation. Outputs during reset: rdata*=0, busy*=0, iss_ready=1, wb_err=0.
- Register 0: always reads 0. Writes to it are ignored. It is never busy. An issue to it is accepted (iss_ready=1) but changes no counter.
- Write: at posedge, if wen && waddr!=0, then mem[waddr]<=wdata. The write happens regardless of the pending count.
- Read: rdata = mem[raddr], combinational. With the optional feature off, a same-cycle write is not visible until the next cycle.
- Issue fire = iss_valid && iss_ready && iss_addr!=0.
- iss_ready = (iss_addr==0) || pend[iss_addr] != all-ones. Depends only on registered state and iss_addr; no path from wen.
- Retire = wen && waddr!=0 && pend[waddr]!=0.
- Counter update per register r:
  - fire only: +1
  - retire only: -1
  - both on same r: unchanged
  - fire and retire on different registers: each updated independently
- Counter never wraps: saturation is prevented by iss_ready. iss_valid while not ready is simply not accepted; the producer holds.
- wen && waddr!=0 && pend[waddr]==0: write performed, counter stays 0, wb_err<=1. wb_err stays set until reset.
- busy = pend[raddr]!=0, from registered counters (subject to the optional feature).

Optional Feature:
Macro REG_FILE_WRITE_BYPASS_EN.
- Defined: same-cycle forwarding. If wen && waddr!=0 && waddr==raddrN, then rdataN=wdata. busyN is cleared when pend[raddrN]==1 and that write retires this cycle. Adds a wdata-to-rdata combinational path.
- Undefined: rdata and busy reflect registered state only. No combinational path from the write port to the read outputs.

Decomposition:
- Shared package reg_file_pkg holds DATA_WIDTH / ADDR_WIDTH / PEND_W defaults and the zero-register index constant (0).
- One natural sub-module, reg_pend_cnt: a single saturating-guarded up/down counter with inc/dec inputs and nonzero/full outputs. It is instantiated REG_NUM-1 times via generate (index 0 omitted). Storage array and read muxes stay in the top level.

Test Plan:
1. Reset: perform writes and issues, then pulse resetn=0 mid-cycle -> all reads 0 immediately; busy1/busy2=0; iss_ready=1; wb_err=0 after release.
2. Write r5=0xDEADBEEF -> next cycle raddr1=5 gives rdata1=0xDEADBEEF. Write r0=0x1234 -> raddr2=0 gives 0.
3. PEND_W=2: issue r3 three times -> iss_ready=0 with iss_addr=3 and busy1=1 (raddr1=3); fourth iss_valid not accepted. Three writebacks to r3 -> busy1 drops after the third, iss_ready=1.
4. pend[7]=1, iss_valid and wen both on r7 in one cycle -> pend[7] stays 1, busy stays 1; next writeback clears it.
5. pend[9]=1, old r9=0x1; wen waddr=9 wdata=0xA5A5A5A5 with raddr2=9 same cycle:
   - with REG_FILE_WRITE_BYPASS_EN: rdata2=0xA5A5A5A5, busy2=0
   - without: rdata2=0x1, busy2=1; next cycle both reflect the write.
6. Writeback to r4 with pend[4]=0, wdata=0x55 -> r4 reads 0x55, wb_err=1 and stays 1 through later traffic until resetn=0.
